// File: rtl/stopwatch_mmss.sv
// MM:SS BCD stopwatch with start/pause/clear control and
// a four-digit multiplexed seven-segment scan for Basys 3.
module stopwatch_mmss #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clock_half,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       running,
  output logic [3:0] sec_o,
  output logic [3:0] sec_t,
  output logic [3:0] min_o,
  output logic [3:0] min_t,
  output logic       rollover,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t state_q, state_d;

  logic [2:0] ch_q, ch_d;
  logic [2:0] bs_q, bs_d;
  logic [2:0] bc_q, bc_d;

  logic [3:0] sec_o_q, sec_o_d;
  logic [3:0] sec_t_q, sec_t_d;
  logic [3:0] min_o_q, min_o_d;
  logic [3:0] min_t_q, min_t_d;
  logic       roll_q, roll_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic tick, start_evt, clr_evt;
  logic inc, clr_time;
  logic [3:0] digit;

  // bit0/bit1 synchronize, bit2 holds history for edge detect
  always_comb begin
    ch_d = {ch_q[1:0], clock_half};
    bs_d = {bs_q[1:0], btn_start};
    bc_d = {bc_q[1:0], btn_clear};
  end

  assign tick      = ch_q[1] & ~ch_q[2];
  assign start_evt = bs_q[1] & ~bs_q[2];
  assign clr_evt   = bc_q[1] & ~bc_q[2];

  always_comb begin
    state_d  = state_q;
    inc      = 1'b0;
    clr_time = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!clr_evt && start_evt)
          state_d = RUN;
      end
      RUN: begin
        if (clr_evt) begin
          state_d  = IDLE;
          clr_time = 1'b1;
        end else if (start_evt) begin
          state_d = PAUSE;
        end else if (tick) begin
          inc = 1'b1;
        end
      end
      PAUSE: begin
        if (clr_evt) begin
          state_d  = IDLE;
          clr_time = 1'b1;
        end else if (start_evt) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sec_o_d = sec_o_q;
    sec_t_d = sec_t_q;
    min_o_d = min_o_q;
    min_t_d = min_t_q;
    roll_d  = 1'b0;
    if (clr_time) begin
      sec_o_d = 4'd0;
      sec_t_d = 4'd0;
      min_o_d = 4'd0;
      min_t_d = 4'd0;
    end else if (inc) begin
      if (sec_o_q == 4'd9) begin
        sec_o_d = 4'd0;
        if (sec_t_q == 4'd5) begin
          sec_t_d = 4'd0;
          if (min_o_q == 4'd9) begin
            min_o_d = 4'd0;
            if (min_t_q == 4'd5) begin
              min_t_d = 4'd0;
              roll_d  = 1'b1;
            end else begin
              min_t_d = min_t_q + 4'd1;
            end
          end else begin
            min_o_d = min_o_q + 4'd1;
          end
        end else begin
          sec_t_d = sec_t_q + 4'd1;
        end
      end else begin
        sec_o_d = sec_o_q + 4'd1;
      end
    end
  end

  // Scan reads live digits so changes appear without waiting a frame
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    sel_d = (cnt_q == LAST) ? sel_q + 2'd1 : sel_q;
    unique case (sel_q)
      2'd0:    digit = sec_o_q;
      2'd1:    digit = sec_t_q;
      2'd2:    digit = min_o_q;
      default: digit = min_t_q;
    endcase
    an_d = ~(4'b0001 << sel_q);
    dp_d = ~(sel_q == 2'd2);
    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      bs_q    <= '0;
      bc_q    <= '0;
      sec_o_q <= '0;
      sec_t_q <= '0;
      min_o_q <= '0;
      min_t_q <= '0;
      roll_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      bs_q    <= bs_d;
      bc_q    <= bc_d;
      sec_o_q <= sec_o_d;
      sec_t_q <= sec_t_d;
      min_o_q <= min_o_d;
      min_t_q <= min_t_d;
      roll_q  <= roll_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign running  = (state_q == RUN);
  assign sec_o    = sec_o_q;
  assign sec_t    = sec_t_q;
  assign min_o    = min_o_q;
  assign min_t    = min_t_q;
  assign rollover = roll_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Directed testbench for stopwatch_mmss with REFRESH_DIV=4.
module tb_stopwatch_mmss;

  logic       clk = 1'b0;
  logic       reset;
  logic       clock_half;
  logic       btn_start;
  logic       btn_clear;
  logic       running;
  logic [3:0] sec_o, sec_t, min_o, min_t;
  logic       rollover;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  stopwatch_mmss #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clock_half (clock_half),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .running    (running),
    .sec_o      (sec_o),
    .sec_t      (sec_t),
    .min_o      (min_o),
    .min_t      (min_t),
    .rollover   (rollover),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] tm();
    return {min_t, min_o, sec_t, sec_o};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    clock_half = 1'b0;
    btn_start  = 1'b0;
    btn_clear  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    clock_half = 1'b1;
    repeat (3) @(negedge clk);
    clock_half = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk);
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tm() !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: time=%h run=%b roll=%b want 0000/0/0",
               tm(), running, rollover);
    end
    total++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_disp: an=%b seg=%b dp=%b want 1110/1000000/1",
               an, seg, dp);
    end
    tick();
    total++;
    if (tm() !== 16'h0000 || running !== 1'b0) begin
      bad++;
      $display("FAIL idle_tick: time=%h run=%b want 0000/0", tm(), running);
    end
  endtask

  task automatic test_run();
    logic [15:0] want;
    do_reset();
    press_start();
    total++;
    if (running !== 1'b1) begin
      bad++;
      $display("FAIL start_run: running=%b want 1", running);
    end
    for (int i = 0; i < 3; i++) begin
      want = 16'(i);
      @(negedge clk);
      clock_half = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (tm() !== want) begin
        bad++;
        $display("FAIL tick_early%0d: time=%h want %h", i, tm(), want);
      end
      @(negedge clk);
      want = 16'(i + 1);
      total++;
      if (tm() !== want) begin
        bad++;
        $display("FAIL tick_lat%0d: time=%h want %h", i, tm(), want);
      end
      clock_half = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (tm() !== want) begin
        bad++;
        $display("FAIL fall_ignored%0d: time=%h want %h", i, tm(), want);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    press_start();
    repeat (5) tick();
    total++;
    if (tm() !== 16'h0005) begin
      bad++;
      $display("FAIL pause_pre: time=%h want 0005", tm());
    end
    press_start();
    repeat (4) tick();
    total++;
    if (tm() !== 16'h0005 || running !== 1'b0) begin
      bad++;
      $display("FAIL pause_hold: time=%h run=%b want 0005/0",
               tm(), running);
    end
    press_start();
    tick();
    total++;
    if (tm() !== 16'h0006 || running !== 1'b1) begin
      bad++;
      $display("FAIL pause_resume: time=%h run=%b want 0006/1",
               tm(), running);
    end
  endtask

  task automatic test_start_tick();
    // running at 00:06: start+tick together pauses without counting
    @(negedge clk);
    btn_start  = 1'b1;
    clock_half = 1'b1;
    repeat (3) @(negedge clk);
    btn_start  = 1'b0;
    clock_half = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tm() !== 16'h0006 || running !== 1'b0) begin
      bad++;
      $display("FAIL st_tick_run: time=%h run=%b want 0006/0",
               tm(), running);
    end
    @(negedge clk);
    btn_start  = 1'b1;
    clock_half = 1'b1;
    repeat (3) @(negedge clk);
    btn_start  = 1'b0;
    clock_half = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tm() !== 16'h0006 || running !== 1'b1) begin
      bad++;
      $display("FAIL st_tick_pause: time=%h run=%b want 0006/1",
               tm(), running);
    end
  endtask

  task automatic test_rollover();
    do_reset();
    press_start();
    repeat (3598) tick();
    total++;
    if (tm() !== 16'h5958) begin
      bad++;
      $display("FAIL preload: time=%h want 5958", tm());
    end
    tick();
    total++;
    if (tm() !== 16'h5959 || rollover !== 1'b0) begin
      bad++;
      $display("FAIL pre_wrap: time=%h roll=%b want 5959/0",
               tm(), rollover);
    end
    @(negedge clk);
    clock_half = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tm() !== 16'h0000 || rollover !== 1'b1 || running !== 1'b1) begin
      bad++;
      $display("FAIL wrap: time=%h roll=%b run=%b want 0000/1/1",
               tm(), rollover, running);
    end
    @(negedge clk);
    total++;
    if (rollover !== 1'b0) begin
      bad++;
      $display("FAIL roll_width: rollover=%b want 0", rollover);
    end
    clock_half = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear_tick();
    do_reset();
    press_start();
    repeat (9) tick();
    @(negedge clk);
    btn_clear  = 1'b1;
    clock_half = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tm() !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
      bad++;
      $display("FAIL clr_tick: time=%h run=%b roll=%b want 0000/0/0",
               tm(), running, rollover);
    end
    btn_clear  = 1'b0;
    clock_half = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    total++;
    if (tm() !== 16'h0000 || running !== 1'b0) begin
      bad++;
      $display("FAIL clr_after: time=%h run=%b want 0000/0",
               tm(), running);
    end
  endtask

  task automatic test_display();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    int guard;
    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100;
    exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001;
    do_reset();
    press_start();
    repeat (754) tick();
    total++;
    if (tm() !== 16'h1234) begin
      bad++;
      $display("FAIL disp_time: time=%h want 1234", tm());
    end
    guard = 0;
    while (an !== 4'b0111 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    while (an === 4'b0111 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 40) begin
      bad++;
      $display("FAIL disp_sync: timeout an=%b", an);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (an !== exp_an[(k / 4) % 4] || seg !== exp_seg[(k / 4) % 4] ||
          dp !== ((k / 4) % 4 != 2)) begin
        bad++;
        $display("FAIL disp_scan%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                 k, an, seg, dp, exp_an[(k / 4) % 4],
                 exp_seg[(k / 4) % 4], ((k / 4) % 4 != 2));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    press_start();
    repeat (197) tick();
    total++;
    if (tm() !== 16'h0317 || running !== 1'b1) begin
      bad++;
      $display("FAIL ar_pre: time=%h run=%b want 0317/1", tm(), running);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (tm() !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0 ||
        an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      bad++;
      $display("FAIL ar_async: time=%h run=%b an=%b seg=%b dp=%b",
               tm(), running, an, seg, dp);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if (tm() !== 16'h0000 || running !== 1'b0) begin
      bad++;
      $display("FAIL ar_ignore: time=%h run=%b want 0000/0",
               tm(), running);
    end
    press_start();
    tick();
    total++;
    if (tm() !== 16'h0001 || running !== 1'b1) begin
      bad++;
      $display("FAIL ar_restart: time=%h run=%b want 0001/1",
               tm(), running);
    end
  endtask

  initial begin
    reset      = 1'b1;
    clock_half = 1'b0;
    btn_start  = 1'b0;
    btn_clear  = 1'b0;
    test_reset();
    test_run();
    test_pause();
    test_start_tick();
    test_rollover();
    test_clear_tick();
    test_display();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
